// File: rtl/seq_alu.sv
// Handshaked sequential ALU: single-cycle base ops plus multi-cycle
// unsigned multiply (shift-add) and divide/remainder (restoring).
module seq_alu #(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             inValid,
   output logic             inReady,
   input  logic [WIDTH-1:0] aluInput1,
   input  logic [WIDTH-1:0] aluInput2,
   input  logic [3:0]       aluControl,
   output logic             outValid,
   input  logic             outReady,
   output logic [WIDTH-1:0] aluOutput,
   output logic [WIDTH-1:0] aluOutputHi,
   output logic             zero,
   output logic             less,
   output logic             overflow,
   output logic             divZero,
   output logic             illegal
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR  = 4'd3,
      OP_XOR  = 4'd4,  OP_SLTU = 4'd5,  OP_SRL  = 4'd6,  OP_SLL = 4'd7,
      OP_SRA  = 4'd8,  OP_MUL  = 4'd9,  OP_DIVU = 4'd10, OP_REMU = 4'd11,
      OP_SLT  = 4'd12
   } op_t;

   localparam int MSB = WIDTH - 1;

   state_t           state, state_nx;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic [SHW-1:0]   cnt_q;

   logic             accept, is_multi, load_out;

   // single-cycle datapath, fed straight from the ports at the accept edge
   logic [WIDTH-1:0] sum, diff, sc_res;
   logic [SHW-1:0]   shamt;
   logic             slt_s, slt_u, sc_less, sc_ovf, sc_ill;

   // iteration datapath
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;
   logic [WIDTH:0]   div_sh;
   logic [WIDTH-1:0] div_diff, div_r_nx, div_q_nx;
   logic             div_ok;

   logic [WIDTH-1:0] fin_res, fin_hi;
   logic             fin_less, fin_ovf, fin_dz, fin_ill;

   assign inReady  = (state == IDLE);
   assign outValid = (state == DONE);
   assign accept   = (state == IDLE) && inValid;
   assign is_multi = (aluControl == OP_MUL) || (aluControl == OP_DIVU) ||
                     (aluControl == OP_REMU);
   assign load_out = (accept && !is_multi) || ((state == BUSY) && (cnt_q == '0));

   assign sum   = aluInput1 + aluInput2;
   assign diff  = aluInput1 - aluInput2;
   assign shamt = aluInput2[SHW-1:0];
   assign slt_s = $signed(aluInput1) < $signed(aluInput2);
   assign slt_u = aluInput1 < aluInput2;

   always_comb begin
      sc_res = '0;
      sc_ovf = 1'b0;
      sc_ill = 1'b0;
      case (aluControl)
         OP_ADD: begin
            sc_res = sum;
            sc_ovf = (aluInput1[MSB] == aluInput2[MSB]) && (sum[MSB] != aluInput1[MSB]);
         end
         OP_SUB: begin
            sc_res = diff;
            sc_ovf = (aluInput1[MSB] != aluInput2[MSB]) && (diff[MSB] != aluInput1[MSB]);
         end
         OP_AND:  sc_res = aluInput1 & aluInput2;
         OP_OR:   sc_res = aluInput1 | aluInput2;
         OP_XOR:  sc_res = aluInput1 ^ aluInput2;
         OP_SLTU: sc_res = WIDTH'(slt_u);
         OP_SRL:  sc_res = aluInput1 >> shamt;
         OP_SLL:  sc_res = aluInput1 << shamt;
         OP_SRA:  sc_res = WIDTH'($signed(aluInput1) >>> shamt);
         OP_SLT:  sc_res = WIDTH'(slt_s);
         OP_MUL, OP_DIVU, OP_REMU: sc_res = '0;
         default: sc_ill = 1'b1;
      endcase
      case (aluControl)
         OP_SUB, OP_SLT: sc_less = slt_s;
         OP_SLTU:        sc_less = slt_u;
         default:        sc_less = sc_res[MSB];
      endcase
   end

   // hi_q:lo_q is the partial product for MUL, remainder:dividend for DIV/REM
   assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
   assign mul_hi_nx = mul_sum[WIDTH:1];
   assign mul_lo_nx = {mul_sum[0], lo_q[MSB:1]};

   assign div_sh   = {hi_q, lo_q[MSB]};
   assign div_ok   = div_sh >= {1'b0, b_q};
   assign div_diff = div_sh[MSB:0] - b_q;
   assign div_r_nx = div_ok ? div_diff : div_sh[MSB:0];
   assign div_q_nx = {lo_q[MSB-1:0], div_ok};

   always_comb begin
      fin_res  = sc_res;
      fin_hi   = '0;
      fin_less = sc_less;
      fin_ovf  = sc_ovf;
      fin_dz   = 1'b0;
      fin_ill  = sc_ill;
      if (state == BUSY) begin
         fin_ovf = 1'b0;
         fin_ill = 1'b0;
         case (op_q)
            OP_MUL: begin
               fin_res = mul_lo_nx;
               fin_hi  = mul_hi_nx;
            end
            OP_DIVU: begin
               fin_res = div_q_nx;
               fin_dz  = (b_q == '0);
            end
            default: begin
               fin_res = div_r_nx;
               fin_dz  = (b_q == '0);
            end
         endcase
         fin_less = fin_res[MSB];
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (inValid) state_nx = is_multi ? BUSY : DONE;
         BUSY:    if (cnt_q == '0) state_nx = DONE;
         DONE:    if (outReady) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state       <= IDLE;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         cnt_q       <= '0;
         aluOutput   <= '0;
         aluOutputHi <= '0;
         zero        <= 1'b0;
         less        <= 1'b0;
         overflow    <= 1'b0;
         divZero     <= 1'b0;
         illegal     <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            op_q  <= aluControl;
            a_q   <= aluInput1;
            b_q   <= aluInput2;
            cnt_q <= SHW'(WIDTH - 1);
            hi_q  <= '0;
            lo_q  <= (aluControl == OP_MUL) ? aluInput2 : aluInput1;
         end else if (state == BUSY) begin
            cnt_q <= cnt_q - SHW'(1);
            if (op_q == OP_MUL) begin
               hi_q <= mul_hi_nx;
               lo_q <= mul_lo_nx;
            end else begin
               hi_q <= div_r_nx;
               lo_q <= div_q_nx;
            end
         end
         if (load_out) begin
            aluOutput   <= fin_res;
            aluOutputHi <= fin_hi;
            zero        <= (fin_res == '0);
            less        <= fin_less;
            overflow    <= fin_ovf;
            divZero     <= fin_dz;
            illegal     <= fin_ill;
         end
      end
   end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, handshaked successor to the single-cycle datapath ALU. It keeps the base op set (add, sub, and, or, xor, slt, shifts) with a one-cycle result. It adds multi-cycle unsigned multiply, divide and remainder, signed compare, true arithmetic shift, and extended flags. It sits between the register-read stage and writeback and stalls the pipeline via inReady/outValid.

Parameters:
WIDTH, 16, operand/result width in bits; must be ≥4 and a power of two.
SHW, log2(WIDTH), derived; shift-amount bits used from operand B.

Ports:
clk  input  1  rising-edge clock.
rstN  input  1  asynchronous active-low reset.
inValid  input  1  operands/op valid this cycle.
inReady  output  1  block can accept an op; high only in IDLE.
aluInput1  input  WIDTH  operand A.
aluInput2  input  WIDTH  operand B.
aluControl  input  4  opcode.
outValid  output  1  result/flags valid; held until outReady.
outReady  input  1  consumer accepts result.
aluOutput  output  WIDTH  result (MUL low half).
aluOutputHi  output  WIDTH  MUL high half; 0 for other ops.
zero  output  1  aluOutput == 0.
less  output  1  see Behaviour.
overflow  output  1  signed overflow, ADD/SUB only.
divZero  output  1  DIVU/REMU with B == 0.
illegal  output  1  opcode 13–15.

Behaviour:
- Reset (rstN low, async):
  - State goes to IDLE.
  - All result/flag outputs are 0 and outValid is 0.
  - Any in-flight operation is discarded.
  - inReady is 1 in IDLE, but inValid is ignored while rstN is low.
- Accept: an op is accepted on a clk edge where inValid && inReady. Operands and opcode are latched at that edge; later changes to the inputs have no effect.
- States:
  - IDLE:
    - Accept of opcode 0–8, 12, or 13–15 → DONE.
    - Accept of opcode 9–11 → BUSY, with counter = WIDTH-1.
  - BUSY: one iteration per cycle; when counter == 0 → DONE; otherwise decrement.
  - DONE: outValid = 1, outputs held stable. outReady → IDLE; no new accept in that same cycle.
- Latency, accept edge to outValid:
  - 1 cycle for single-cycle ops.
  - WIDTH+1 cycles for opcodes 9–11.
  - Peak throughput is one op per 2 cycles.
- Opcodes (all arithmetic is modulo 2^WIDTH unless stated):
  - 0 ADD; 1 SUB; 2 AND; 3 OR; 4 XOR.
  - 5 SLTU: 1 if A<B unsigned, else 0.
  - 6 SRL; 7 SLL; 8 SRA, sign-filled from A[WIDTH-1].
  - 9 MUL: unsigned shift-add; low half on aluOutput, high half on aluOutputHi.
  - 10 DIVU: restoring division, quotient.
  - 11 REMU: restoring division, remainder.
  - 12 SLT: 1 if A<B signed, else 0.
  - 13–15: aluOutput = 0, illegal = 1.
- Shifts:
  - Amount is B[SHW-1:0]; upper bits of B are ignored.
  - Amount 0 returns A unchanged.
- Divide by zero:
  - Still takes WIDTH+1 cycles.
  - DIVU gives all-ones; REMU gives A.
  - divZero = 1.
- Flags, registered with the result and valid only while outValid:
  - zero = (aluOutput == 0).
  - less = signed A<B for SUB and SLT; unsigned A<B for SLTU; aluOutput[WIDTH-1] for all other ops.
  - overflow:
    - ADD: A and B have the same sign and the result sign differs.
    - SUB: A and B differ in sign and the result sign differs from A.
    - 0 for all other ops.
  - divZero and illegal are 0 except as stated above.
- outReady asserted outside DONE is ignored. inValid outside IDLE is ignored; the producer must hold it.

Test Plan:
1. WIDTH=16. ADD 0x7FFF+0x0001 → outValid one cycle after accept; aluOutput=0x8000, overflow=1, less=1, zero=0. Then SUB 5-5 → aluOutput=0, zero=1, less=0.
2. SLT A=0xFFFF, B=0x0001 → aluOutput=1, less=1. SLTU with the same operands → aluOutput=0, less=0. SRA 0x8000 by B=0x0013 (amount 3) → 0xF000. SRL of the same → 0x1000.
3. MUL 0xFFFF×0xFFFF → outValid exactly 17 cycles after accept; aluOutput=0x0001, aluOutputHi=0xFFFE. inReady=0 throughout BUSY.
4. DIVU 100/7 → 14; REMU 100/7 → 2. DIVU 9/0 → 0xFFFF, divZero=1. REMU 9/0 → 9, divZero=1. All at 17-cycle latency.
5. Hold outReady=0 for 5 cycles in DONE → outputs stable and inValid ignored. Then outReady=1 → IDLE next cycle. Also opcode 14 → aluOutput=0, illegal=1, zero=1.
6. Drop rstN mid-MUL at BUSY cycle 8 → outputs 0 immediately, asynchronously. After release, a new ADD 2+3 → 5 with normal 1-cycle latency.
